// File: rtl/udp_rx_slot_ctrl_pkg.sv
// Shared types for the UDP receive slot controller: write-FSM states and
// drop-cause codes kept alongside the drop pulse for debug visibility.
package udp_rx_slot_ctrl_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_DROP = 2'd2
  } wstate_e;

  typedef enum logic [2:0] {
    DC_NONE    = 3'd0,
    DC_TRUNC   = 3'd1,
    DC_BAD     = 3'd2,
    DC_FULL    = 3'd3,
    DC_RESTART = 3'd4
  } drop_cause_e;

endpackage

// File: rtl/udp_rx_desc_ring.sv
// Descriptor ring: per-slot committed lengths, fill/read pointers and the
// occupied-slot counter. Release is ignored while nothing is committed.
module udp_rx_desc_ring #(
  parameter int unsigned LEN_W = 11,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit_i,
  input  logic [LEN_W-1:0] commit_len_i,
  input  logic             release_i,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [LEN_W-1:0] rd_len_o,
  output logic [PTR_W:0]   used_o,
  output logic             avail_o
);

  localparam int unsigned NSLOT = 1 << PTR_W;

  logic [LEN_W-1:0] len_q [NSLOT];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   used_q, used_d;
  logic             rel;

  assign avail_o  = (used_q != '0);
  assign rel      = release_i && avail_o;
  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign rd_len_o = len_q[rd_ptr_q];
  assign used_o   = used_q;

  always_comb begin
    used_d = used_q;
    unique case ({commit_i, rel})
      2'b10:   used_d = used_q + (PTR_W+1)'(1);
      2'b01:   used_d = used_q - (PTR_W+1)'(1);
      default: used_d = used_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NSLOT; i++) len_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
    end else begin
      if (commit_i) begin
        len_q[wr_ptr_q] <= commit_len_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (rel) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      used_q <= used_d;
    end
  end

endmodule

// File: rtl/udp_rx_slot_ctrl.sv
// Receive-buffer slot controller: steers receiver bytes into the current ring
// slot, commits good frames as length descriptors and discards the rest.
module udp_rx_slot_ctrl
  import udp_rx_slot_ctrl_pkg::*;
#(
  parameter int unsigned SLOT_POW2  = 10,
  parameter int unsigned NSLOT_POW2 = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_start,
  input  logic                             wr_valid,
  input  logic [7:0]                       wr_data,
  input  logic                             wr_end,
  input  logic                             wr_ok,
  output logic                             mem_we,
  output logic [NSLOT_POW2+SLOT_POW2-1:0]  mem_waddr,
  output logic [7:0]                       mem_wdata,
  output logic [NSLOT_POW2+SLOT_POW2-1:0]  mem_raddr,
  input  logic [7:0]                       mem_rdata,
  output logic                             rd_avail,
  output logic [SLOT_POW2:0]               rd_len,
  input  logic [SLOT_POW2-1:0]             rd_offset,
  input  logic                             rd_req,
  output logic                             rd_dvalid,
  input  logic                             rd_release,
  output logic                             drop_pulse,
  output logic [15:0]                      drop_cnt,
  output logic [NSLOT_POW2:0]              used
);

  localparam int unsigned L  = SLOT_POW2;
  localparam int unsigned S  = NSLOT_POW2;
  localparam int unsigned AW = S + L;
  localparam logic [S:0] NSLOT      = {1'b1, {S{1'b0}}};
  localparam logic [L:0] SLOT_BYTES = {1'b1, {L{1'b0}}};

  wstate_e          state_q, state_d;
  drop_cause_e      cause_q, cause_d;
  logic [L:0]       off_q, off_d, off_v;
  logic             trunc_q, trunc_d, trunc_v;
  logic             we_q, we_d;
  logic [AW-1:0]    waddr_q, waddr_d;
  logic [7:0]       wdata_q;
  logic [15:0]      drop_cnt_q;
  logic             rd_dvalid_q;
  logic             ended;
  logic             commit;
  logic [L:0]       commit_len;
  logic [S-1:0]     wr_ptr, rd_ptr;
  logic [S:0]       used_w, used_eff;

  udp_rx_desc_ring #(
    .LEN_W (L + 1),
    .PTR_W (S)
  ) u_ring (
    .clk          (clk),
    .rst          (rst),
    .commit_i     (commit),
    .commit_len_i (commit_len),
    .release_i    (rd_release),
    .wr_ptr_o     (wr_ptr),
    .rd_ptr_o     (rd_ptr),
    .rd_len_o     (rd_len),
    .used_o       (used_w),
    .avail_o      (rd_avail)
  );

  // A commit in the same cycle counts against the full check for an immediate
  // restart; a same-cycle release does not free room.
  assign used_eff = used_w + (S+1)'(commit);

  always_comb begin
    state_d    = state_q;
    cause_d    = DC_NONE;
    off_v      = off_q;
    trunc_v    = trunc_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    commit     = 1'b0;
    commit_len = off_q;
    ended      = 1'b0;

    unique case (state_q)
      W_FILL: begin
        if (wr_valid) begin
          if (off_q == SLOT_BYTES) begin
            trunc_v = 1'b1;
          end else begin
            we_d    = 1'b1;
            waddr_d = {wr_ptr, off_q[L-1:0]};
            off_v   = off_q + (L+1)'(1);
          end
        end
        if (wr_end) begin
          ended   = 1'b1;
          state_d = W_IDLE;
          if (wr_ok && !trunc_v) begin
            commit     = 1'b1;
            commit_len = off_v;
          end else begin
            cause_d = trunc_v ? DC_TRUNC : DC_BAD;
          end
        end else if (wr_start) begin
          cause_d = DC_RESTART;
        end
      end
      W_DROP: begin
        if (wr_end) begin
          ended   = 1'b1;
          state_d = W_IDLE;
          cause_d = DC_FULL;
        end
      end
      default: ;
    endcase

    off_d   = off_v;
    trunc_d = trunc_v;
    if (wr_start && (state_q != W_DROP || ended)) begin
      if (used_eff == NSLOT) begin
        state_d = W_DROP;
      end else begin
        state_d = W_FILL;
        off_d   = '0;
        trunc_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= W_IDLE;
      cause_q     <= DC_NONE;
      off_q       <= '0;
      trunc_q     <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      drop_cnt_q  <= '0;
      rd_dvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      off_q       <= off_d;
      trunc_q     <= trunc_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      if (we_d) wdata_q <= wr_data;
      if (cause_d != DC_NONE && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 16'd1;
      rd_dvalid_q <= rd_req;
    end
  end

  assign mem_we     = we_q;
  assign mem_waddr  = waddr_q;
  assign mem_wdata  = wdata_q;
  assign mem_raddr  = {rd_ptr, rd_offset};
  assign rd_dvalid  = rd_dvalid_q;
  assign drop_pulse = (cause_q != DC_NONE);
  assign drop_cnt   = drop_cnt_q;
  assign used       = used_w;

  // Read data passes straight through from the external memory.
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;

endmodule
